// File: rtl/argon_fetch_pkg.sv
// Shared types and constants for the prefetching instruction fetch unit.
package argon_fetch_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    REQ  = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam logic [3:0] WB_SEL_ALL = 4'b1111;

  // Redirect targets are word aligned; the low two bits are simply cleared.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/wishbone_if.sv
// Classic Wishbone signal bundle used by the fetch unit as a read-only master.
interface wishbone_if;
  logic        cycle;
  logic        strobe;
  logic [3:0]  select;
  logic [31:0] address;
  logic        write_enable;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        ack;

  modport master (
    output cycle, strobe, select, address, write_enable, data_in,
    input  data_out, ack
  );

  modport slave (
    input  cycle, strobe, select, address, write_enable, data_in,
    output data_out, ack
  );
endinterface

// File: rtl/fetch_fifo.sv
// Circular prefetch buffer; the head entry is read straight from the register array.
// Flush empties the buffer and takes priority over push and pop.
module fetch_fifo
  import argon_fetch_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  entry_t                 push_data,
  output entry_t                 head,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            push_ok;
  logic            pop_ok;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    push_ok  = push && !full;
    pop_ok   = pop && !empty;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/instruction_prefetch.sv
// Instruction fetch unit: issues single outstanding Wishbone reads ahead of decode and
// buffers the results; a branch flushes the buffer and discards any read still in flight.
module instruction_prefetch
  import argon_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_branch_enable,
  input  logic [31:0] i_branch_address,
  input  logic        i_ready,
  wishbone_if.master  wishbone_bus,
  output logic [31:0] o_instruction,
  output logic [31:0] o_pc,
  output logic        o_valid
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t  state_q, state_d;
  logic          cyc_q, cyc_d;
  logic [31:0]   adr_q, adr_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   seq_pc;
  logic          discard_q, discard_d;

  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_empty;
  logic          fifo_full;
  logic [CW-1:0] fifo_count;
  logic          can_issue;
  fetch_entry_t  push_entry;
  fetch_entry_t  head_entry;

  assign can_issue  = (fifo_count < CW'(FIFO_DEPTH));
  assign fifo_pop   = !fifo_empty && i_ready && !i_branch_enable;
  assign push_entry = '{pc: fetch_pc_q, instr: wishbone_bus.data_out};

  fetch_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (fetch_entry_t)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .pop       (fifo_pop),
    .flush     (i_branch_enable),
    .push_data (push_entry),
    .head      (head_entry),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  // Bus FSM next-state; a branch overrides the PC whatever the state.
  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    adr_d     = adr_q;
    discard_d = discard_q;
    seq_pc    = fetch_pc_q;
    fifo_push = 1'b0;
    case (state_q)
      IDLE: begin
        if (can_issue && !i_branch_enable) begin
          cyc_d   = 1'b1;
          adr_d   = fetch_pc_q;
          state_d = REQ;
        end else begin
          cyc_d = 1'b0;
        end
      end
      REQ: begin
        if (wishbone_bus.ack) begin
          cyc_d   = 1'b0;
          state_d = IDLE;
          if (discard_q) begin
            discard_d = 1'b0;
          end else if (!i_branch_enable && !fifo_full) begin
            fifo_push = 1'b1;
            seq_pc    = fetch_pc_q + 32'd4;
          end else begin
            fifo_push = 1'b0;
          end
        end else if (i_branch_enable) begin
          // The ack still has to be consumed, but its data belongs to the old path.
          discard_d = 1'b1;
        end else begin
          discard_d = discard_q;
        end
      end
      default: begin
        state_d   = IDLE;
        cyc_d     = 1'b0;
        discard_d = 1'b0;
      end
    endcase
    fetch_pc_d = i_branch_enable ? word_align(i_branch_address) : seq_pc;
  end

  // Bus FSM and fetch bookkeeping registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cyc_q      <= 1'b0;
      adr_q      <= RESET_PC;
      fetch_pc_q <= RESET_PC;
      discard_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      adr_q      <= adr_d;
      fetch_pc_q <= fetch_pc_d;
      discard_q  <= discard_d;
    end
  end

  assign wishbone_bus.cycle        = cyc_q;
  assign wishbone_bus.strobe       = cyc_q;
  assign wishbone_bus.select       = WB_SEL_ALL;
  assign wishbone_bus.address      = adr_q;
  assign wishbone_bus.write_enable = 1'b0;
  assign wishbone_bus.data_in      = 32'h0000_0000;

  // Decode-side view of the head entry; zeros when nothing is buffered.
  always_comb begin
    o_valid = !fifo_empty;
    if (fifo_empty) begin
      o_instruction = 32'h0000_0000;
      o_pc          = 32'h0000_0000;
    end else begin
      o_instruction = head_entry.instr;
      o_pc          = head_entry.pc;
    end
  end

endmodule

// File: tb/tb_instruction_prefetch.sv
// Directed bench for instruction_prefetch with a latency-programmable Wishbone slave.
module tb_instruction_prefetch;
  logic        clk = 1'b0;
  logic        reset;
  logic        i_branch_enable;
  logic [31:0] i_branch_address;
  logic        i_ready;
  logic [31:0] o_instruction;
  logic [31:0] o_pc;
  logic        o_valid;

  wishbone_if wb();

  instruction_prefetch #(.RESET_PC(32'h0000_0100), .FIFO_DEPTH(4)) dut (
    .clk              (clk),
    .reset            (reset),
    .i_branch_enable  (i_branch_enable),
    .i_branch_address (i_branch_address),
    .i_ready          (i_ready),
    .wishbone_bus     (wb),
    .o_instruction    (o_instruction),
    .o_pc             (o_pc),
    .o_valid          (o_valid)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc_no = 0;
  logic [31:0] req_addr[$];
  logic [31:0] acc_pc[$];
  logic [31:0] acc_ins[$];
  int ack_cyc[$];
  int acc_cyc[$];

  int          slave_cnt = 0;
  int          slow_lat = 1;
  logic [31:0] slow_addr = 32'h0000_0001;
  logic [31:0] force_addr = 32'h0000_0001;
  logic [31:0] force_val = 32'h0000_0000;

  // Slave: ack after a per-address wait; read data is the inverted address unless forced.
  initial begin
    wb.ack = 1'b0;
    wb.data_out = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (wb.cycle && wb.strobe) begin
        slave_cnt++;
        if (slave_cnt >= ((wb.address == slow_addr) ? slow_lat : 1)) begin
          wb.ack = 1'b1;
          wb.data_out = (wb.address == force_addr) ? force_val : ~wb.address;
        end else begin
          wb.ack = 1'b0;
          wb.data_out = 32'h0;
        end
      end else begin
        slave_cnt = 0;
        wb.ack = 1'b0;
        wb.data_out = 32'h0;
      end
    end
  end

  // Monitor: log completed bus reads and entries accepted by decode.
  initial begin
    forever begin
      @(negedge clk);
      cyc_no++;
      if (wb.cycle && wb.strobe && wb.ack) begin
        req_addr.push_back(wb.address);
        ack_cyc.push_back(cyc_no);
      end
      if (o_valid && i_ready && !i_branch_enable && !reset) begin
        acc_pc.push_back(o_pc);
        acc_ins.push_back(o_instruction);
        acc_cyc.push_back(cyc_no);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    req_addr.delete();
    acc_pc.delete();
    acc_ins.delete();
    ack_cyc.delete();
    acc_cyc.delete();
  endtask

  task automatic do_reset(input logic ready);
    reset = 1'b1;
    i_branch_enable = 1'b0;
    i_ready = ready;
    clear_logs();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_req(input logic [31:0] a);
    bit found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (wb.cycle && wb.strobe && wb.address == a) found = 1'b1;
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL wait_req: request to %h not seen, want within 60 cycles", a);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    i_branch_enable = 1'b0;
    i_branch_address = 32'h0;
    i_ready = 1'b0;
    @(negedge clk);
    total += 9;
    if (wb.cycle !== 1'b0) begin bad++; $display("FAIL reset_cycle: got=%b want=0", wb.cycle); end
    if (wb.strobe !== 1'b0) begin bad++; $display("FAIL reset_strobe: got=%b want=0", wb.strobe); end
    if (wb.select !== 4'b1111) begin bad++; $display("FAIL reset_select: got=%b want=1111", wb.select); end
    if (wb.write_enable !== 1'b0) begin bad++; $display("FAIL reset_we: got=%b want=0", wb.write_enable); end
    if (wb.data_in !== 32'h0) begin bad++; $display("FAIL reset_data_in: got=%h want=0", wb.data_in); end
    if (wb.address !== 32'h100) begin bad++; $display("FAIL reset_address: got=%h want=100", wb.address); end
    if (o_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got=%b want=0", o_valid); end
    if (o_instruction !== 32'h0) begin bad++; $display("FAIL reset_instr: got=%h want=0", o_instruction); end
    if (o_pc !== 32'h0) begin bad++; $display("FAIL reset_pc: got=%h want=0", o_pc); end
    tick();
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    total += 2;
    if (wb.cycle !== 1'b1 || wb.strobe !== 1'b1) begin
      bad++; $display("FAIL first_req: got cyc=%b stb=%b want 1 1", wb.cycle, wb.strobe);
    end
    if (wb.address !== 32'h100) begin bad++; $display("FAIL first_addr: got=%h want=100", wb.address); end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc [3] = '{32'h100, 32'h104, 32'h108};
    logic [31:0] exp_in [3] = '{32'hFFFF_FEFF, 32'hFFFF_FEFB, 32'hFFFF_FEF7};
    do_reset(1'b1);
    repeat (14) tick();
    for (int i = 0; i < 3; i++) begin
      total += 3;
      if (req_addr[i] !== exp_pc[i]) begin bad++; $display("FAIL seq_addr[%0d]: got=%h want=%h", i, req_addr[i], exp_pc[i]); end
      if (acc_pc[i] !== exp_pc[i]) begin bad++; $display("FAIL seq_pc[%0d]: got=%h want=%h", i, acc_pc[i], exp_pc[i]); end
      if (acc_ins[i] !== exp_in[i]) begin bad++; $display("FAIL seq_instr[%0d]: got=%h want=%h", i, acc_ins[i], exp_in[i]); end
    end
    total += 2;
    if (ack_cyc[1] - ack_cyc[0] !== 2) begin bad++; $display("FAIL seq_rate: got=%0d want=2 cycles", ack_cyc[1] - ack_cyc[0]); end
    if (acc_cyc[0] - ack_cyc[0] !== 1) begin bad++; $display("FAIL seq_latency: got=%0d want=1 cycle", acc_cyc[0] - ack_cyc[0]); end
  endtask

  task automatic test_full();
    do_reset(1'b0);
    repeat (20) tick();
    total += 5;
    if (req_addr.size() !== 4) begin bad++; $display("FAIL full_reqs: got=%0d want=4", req_addr.size()); end
    if (req_addr[3] !== 32'h10C) begin bad++; $display("FAIL full_last: got=%h want=10c", req_addr[3]); end
    if (wb.cycle !== 1'b0) begin bad++; $display("FAIL full_idle: got=%b want=0", wb.cycle); end
    if (o_pc !== 32'h100) begin bad++; $display("FAIL full_head_pc: got=%h want=100", o_pc); end
    if (o_instruction !== 32'hFFFF_FEFF) begin bad++; $display("FAIL full_head_in: got=%h want=fffffeff", o_instruction); end
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    total += 1;
    if (o_pc !== 32'h104) begin bad++; $display("FAIL full_pop_pc: got=%h want=104", o_pc); end
    tick();
    total += 1;
    if (wb.cycle !== 1'b1 || wb.address !== 32'h110) begin
      bad++; $display("FAIL full_refill: got cyc=%b addr=%h want 1 110", wb.cycle, wb.address);
    end
    repeat (8) tick();
    total += 3;
    if (req_addr.size() !== 5) begin bad++; $display("FAIL full_reqs2: got=%0d want=5", req_addr.size()); end
    if (wb.cycle !== 1'b0) begin bad++; $display("FAIL full_idle2: got=%b want=0", wb.cycle); end
    if (acc_pc.size() !== 1) begin bad++; $display("FAIL full_pops: got=%0d want=1", acc_pc.size()); end
  endtask

  task automatic test_branch_discard();
    bit seen_bad = 1'b0;
    slow_addr = 32'h10C;
    slow_lat = 4;
    force_addr = 32'h10C;
    force_val = 32'hDEAD_BEEF;
    do_reset(1'b1);
    wait_req(32'h10C);
    tick();
    i_branch_enable = 1'b1;
    i_branch_address = 32'h0000_2002;
    tick();
    i_branch_enable = 1'b0;
    @(negedge clk);
    total += 1;
    if (o_valid !== 1'b0) begin bad++; $display("FAIL disc_valid: got=%b want=0", o_valid); end
    repeat (15) tick();
    foreach (acc_ins[i]) if (acc_ins[i] === 32'hDEAD_BEEF) seen_bad = 1'b1;
    total += 5;
    if (seen_bad) begin bad++; $display("FAIL disc_leak: got deadbeef on o_instruction want never"); end
    if (req_addr[3] !== 32'h10C) begin bad++; $display("FAIL disc_old: got=%h want=10c", req_addr[3]); end
    if (req_addr[4] !== 32'h2000) begin bad++; $display("FAIL disc_target: got=%h want=2000", req_addr[4]); end
    if (acc_pc[3] !== 32'h2000) begin bad++; $display("FAIL disc_pc: got=%h want=2000", acc_pc[3]); end
    if (acc_ins[3] !== 32'hFFFF_DFFF) begin bad++; $display("FAIL disc_instr: got=%h want=ffffdfff", acc_ins[3]); end
    slow_addr = 32'h1;
    force_addr = 32'h1;
  endtask

  task automatic test_branch_with_ack();
    slow_addr = 32'h108;
    slow_lat = 3;
    do_reset(1'b0);
    wait_req(32'h108);
    tick();
    tick();
    i_ready = 1'b1;
    i_branch_enable = 1'b1;
    i_branch_address = 32'h0000_3001;
    @(negedge clk);
    total += 2;
    if (wb.ack !== 1'b1) begin bad++; $display("FAIL bwa_ack: got=%b want=1", wb.ack); end
    if (o_valid !== 1'b1) begin bad++; $display("FAIL bwa_buffered: got=%b want=1", o_valid); end
    tick();
    i_branch_enable = 1'b0;
    @(negedge clk);
    total += 1;
    if (o_valid !== 1'b0) begin bad++; $display("FAIL bwa_valid: got=%b want=0", o_valid); end
    repeat (12) tick();
    total += 3;
    if (req_addr[3] !== 32'h3000) begin bad++; $display("FAIL bwa_target: got=%h want=3000", req_addr[3]); end
    if (acc_pc[0] !== 32'h3000) begin bad++; $display("FAIL bwa_pc: got=%h want=3000", acc_pc[0]); end
    if (acc_ins[0] !== 32'hFFFF_CFFF) begin bad++; $display("FAIL bwa_instr: got=%h want=ffffcfff", acc_ins[0]); end
    slow_addr = 32'h1;
  endtask

  task automatic test_wrap_push_pop();
    logic [31:0] exp_pc [6] = '{32'hFFFF_FFF4, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4, 32'h8};
    logic [31:0] exp_in [6] = '{32'h0000_000B, 32'h0000_0007, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 32'hFFFF_FFF7};
    reset = 1'b1;
    i_ready = 1'b0;
    clear_logs();
    tick();
    tick();
    reset = 1'b0;
    i_branch_enable = 1'b1;
    i_branch_address = 32'hFFFF_FFF4;
    tick();
    i_branch_enable = 1'b0;
    @(negedge clk);
    total += 1;
    if (wb.cycle !== 1'b0) begin bad++; $display("FAIL wrap_suppress: got=%b want=0", wb.cycle); end
    tick();
    total += 1;
    if (wb.cycle !== 1'b1 || wb.address !== 32'hFFFF_FFF4) begin
      bad++; $display("FAIL wrap_first: got cyc=%b addr=%h want 1 fffffff4", wb.cycle, wb.address);
    end
    wait_req(32'hFFFF_FFFC);
    tick();
    tick();
    i_ready = 1'b1;
    @(negedge clk);
    total += 1;
    if (wb.address !== 32'h0 || wb.ack !== 1'b1) begin
      bad++; $display("FAIL wrap_addr0: got addr=%h ack=%b want 0 1", wb.address, wb.ack);
    end
    tick();
    i_ready = 1'b0;
    total += 1;
    if (o_pc !== 32'hFFFF_FFF8) begin bad++; $display("FAIL wrap_head: got=%h want=fffffff8", o_pc); end
    repeat (10) tick();
    total += 3;
    if (req_addr.size() !== 5) begin bad++; $display("FAIL wrap_reqs: got=%0d want=5", req_addr.size()); end
    if (req_addr[4] !== 32'h4) begin bad++; $display("FAIL wrap_last: got=%h want=4", req_addr[4]); end
    if (wb.cycle !== 1'b0) begin bad++; $display("FAIL wrap_full: got=%b want=0", wb.cycle); end
    i_ready = 1'b1;
    repeat (14) tick();
    for (int i = 0; i < 6; i++) begin
      total += 2;
      if (acc_pc[i] !== exp_pc[i]) begin bad++; $display("FAIL wrap_pc[%0d]: got=%h want=%h", i, acc_pc[i], exp_pc[i]); end
      if (acc_ins[i] !== exp_in[i]) begin bad++; $display("FAIL wrap_instr[%0d]: got=%h want=%h", i, acc_ins[i], exp_in[i]); end
    end
  endtask

  task automatic test_async_reset();
    slow_addr = 32'h108;
    slow_lat = 50;
    do_reset(1'b0);
    wait_req(32'h108);
    total += 2;
    if (o_valid !== 1'b1) begin bad++; $display("FAIL ar_pre_valid: got=%b want=1", o_valid); end
    if (o_pc !== 32'h100) begin bad++; $display("FAIL ar_pre_pc: got=%h want=100", o_pc); end
    #2;
    reset = 1'b1;
    #1;
    total += 6;
    if (wb.cycle !== 1'b0) begin bad++; $display("FAIL ar_cycle: got=%b want=0", wb.cycle); end
    if (wb.strobe !== 1'b0) begin bad++; $display("FAIL ar_strobe: got=%b want=0", wb.strobe); end
    if (wb.address !== 32'h100) begin bad++; $display("FAIL ar_address: got=%h want=100", wb.address); end
    if (o_valid !== 1'b0) begin bad++; $display("FAIL ar_valid: got=%b want=0", o_valid); end
    if (o_pc !== 32'h0) begin bad++; $display("FAIL ar_pc: got=%h want=0", o_pc); end
    if (o_instruction !== 32'h0) begin bad++; $display("FAIL ar_instr: got=%h want=0", o_instruction); end
    slow_addr = 32'h1;
    tick();
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    total += 1;
    if (wb.cycle !== 1'b1 || wb.address !== 32'h100) begin
      bad++; $display("FAIL ar_restart: got cyc=%b addr=%h want 1 100", wb.cycle, wb.address);
    end
    repeat (6) tick();
    total += 2;
    if (o_pc !== 32'h100) begin bad++; $display("FAIL ar_head_pc: got=%h want=100", o_pc); end
    if (o_instruction !== 32'hFFFF_FEFF) begin bad++; $display("FAIL ar_head_in: got=%h want=fffffeff", o_instruction); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_full();
    test_branch_discard();
    test_branch_with_ack();
    test_wrap_push_pop();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
